// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   br_cond_e : branch compare-mode codes carried on br_cond
//   state_e   : sequencer FSM states
//   src_e     : next-PC source chosen by the priority mux
//   br_taken  : branch outcome from the compare mode and the execute flags
package pc_pkg;

   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd4,
      BR_GE  = 3'd5,
      BR_LTU = 3'd6,
      BR_GEU = 3'd7
   } br_cond_e;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      SRC_HOLD   = 3'd0,
      SRC_SEQ    = 3'd1,
      SRC_BRANCH = 3'd2,
      SRC_JUMP   = 3'd3,
      SRC_RET    = 3'd4,
      SRC_TRAP   = 3'd5
   } src_e;

   // Codes 2 and 3 are unused and are never taken.
   function automatic logic br_taken(input logic [2:0] cond,
                                     input logic       zero,
                                     input logic       lt,
                                     input logic       ltu);
      logic res;
      res = 1'b0;
      case (cond)
         BR_EQ:   res = zero;
         BR_NE:   res = ~zero;
         BR_LT:   res = lt;
         BR_GE:   res = ~lt;
         BR_LTU:  res = ltu;
         BR_GEU:  res = ~ltu;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the execute/fetch side and the PC sequencer.
//   master : drives fetch handshake, control and redirect requests; reads pc state
//   slave  : the sequencer; reads requests, drives pc, pc_valid, pc_plus,
//            redirect and the RAS status flags
interface pc_sequencer_if #(
   parameter int XLEN = 32
);
   logic            fetch_ready;
   logic            stall;
   logic            halt;
   logic            resume;
   logic            branch;
   logic [2:0]      br_cond;
   logic            cmp_zero;
   logic            cmp_lt;
   logic            cmp_ltu;
   logic [XLEN-1:0] branch_target;
   logic            jump;
   logic            jump_link;
   logic [XLEN-1:0] jump_target;
   logic            ret;
   logic            trap;
   logic [XLEN-1:0] trap_vector;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [XLEN-1:0] pc_plus;
   logic            redirect;
   logic            ras_empty;
   logic            ras_full;

   modport master (
      output fetch_ready, stall, halt, resume,
      output branch, br_cond, cmp_zero, cmp_lt, cmp_ltu, branch_target,
      output jump, jump_link, jump_target, ret, trap, trap_vector,
      input  pc, pc_valid, pc_plus, redirect, ras_empty, ras_full
   );

   modport slave (
      input  fetch_ready, stall, halt, resume,
      input  branch, br_cond, cmp_zero, cmp_lt, cmp_ltu, branch_target,
      input  jump, jump_link, jump_target, ret, trap, trap_vector,
      output pc, pc_valid, pc_plus, redirect, ras_empty, ras_full
   );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   push/push_data : store a return address; when full the oldest entry is
//                    overwritten and the count stays saturated
//   pop            : discard the top entry; ignored when empty
//   top            : most recently pushed live entry (don't-care when empty)
//   empty/full     : occupancy flags
module pc_ras #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] mem_q [RAS_DEPTH];
   logic [XLEN-1:0] mem_d [RAS_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   top_idx;

   // wr_ptr is the next slot to write; the top lives one slot behind it.
   assign top_idx = wr_ptr_q - PW'(1);
   assign top     = mem_q[top_idx];
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(RAS_DEPTH));

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         if (!full) begin
            count_d = count_q + CW'(1);
         end
      end else if (pop && !empty) begin
         wr_ptr_d = top_idx;
         count_d  = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: generates the fetch PC and picks the next PC from
// sequential advance, taken branch, jump/call, return (RAS) or trap.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of pc_sequencer_if (requests in, pc state out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | one cycle after reset; no fetch, redirects ignored
// ST_RUN  | fetching; sequential advance and all redirect sources active
// ST_HALT | no fetch, pc held; only trap (redirect + run) or resume leave
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INSTR_BYTES  = 4,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.slave bus
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            redirect_q, redirect_d;
   src_e            src;
   logic            taken;
   logic            redir_req;
   logic [XLEN-1:0] pc_plus;
   logic            ras_push, ras_pop;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty, ras_full;

   assign pc_plus = pc_q + XLEN'(INSTR_BYTES);

   assign bus.pc        = pc_q;
   assign bus.pc_plus   = pc_plus;
   // Decoded straight from the state flop so an async reset drops it at once.
   assign bus.pc_valid  = (state_q == ST_RUN);
   assign bus.redirect  = redirect_q;
   assign bus.ras_empty = ras_empty;
   assign bus.ras_full  = ras_full;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      src        = SRC_HOLD;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      redirect_d = 1'b0;
      taken      = bus.branch & br_taken(bus.br_cond, bus.cmp_zero, bus.cmp_lt, bus.cmp_ltu);
      redir_req  = bus.trap | bus.ret | bus.jump | taken;

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (bus.trap)                            src = SRC_TRAP;
            else if (bus.ret)                        src = SRC_RET;
            else if (bus.jump)                       src = SRC_JUMP;
            else if (taken)                          src = SRC_BRANCH;
            else if (bus.fetch_ready && !bus.stall)  src = SRC_SEQ;
            // A pending redirect keeps us running so it is not lost.
            if (bus.halt && !redir_req) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (bus.trap) begin
               src     = SRC_TRAP;
               state_d = ST_RUN;
            end else if (bus.resume) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_BOOT;
      endcase

      case (src)
         SRC_TRAP:   pc_d = bus.trap_vector & ALIGN_MASK;
         SRC_RET:    pc_d = (ras_empty ? pc_plus : ras_top) & ALIGN_MASK;
         SRC_JUMP:   pc_d = bus.jump_target & ALIGN_MASK;
         SRC_BRANCH: pc_d = bus.branch_target & ALIGN_MASK;
         SRC_SEQ:    pc_d = pc_plus;
         default:    pc_d = pc_q;
      endcase

      ras_push   = (src == SRC_JUMP) && bus.jump_link;
      ras_pop    = (src == SRC_RET);
      redirect_d = (src == SRC_TRAP) || (src == SRC_RET) ||
                   (src == SRC_JUMP) || (src == SRC_BRANCH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
      end
   end

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

endmodule
